vmicro16_cond_unit: RTL

//  Per-thread NZCV flag register file plus registered condition evaluator for vmicro16 cores.

---
 rtl/vmicro16_cond_unit_pkg.sv | 21 ++
 rtl/vmicro16_flag_stack.sv | 41 ++++
 rtl/vmicro16_cond_unit.sv | 117 +++++++++++
 3 files changed

// File: rtl/vmicro16_cond_unit_pkg.sv
// Shared flag layout and branch-condition encodings for the vmicro16 condition unit.
package vmicro16_cond_unit_pkg;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef logic [3:0] nzcv_t;

    typedef enum logic [7:0] {
        BR_U  = 8'h00,
        BR_E  = 8'h01,
        BR_NE = 8'h02,
        BR_G  = 8'h03,
        BR_GE = 8'h04,
        BR_L  = 8'h05,
        BR_LE = 8'h06
    } br_cond_e;

endpackage

// File: rtl/vmicro16_flag_stack.sv
// Per-thread LIFO of saved NZCV values; callers never assert push and pop together.
module vmicro16_flag_stack
    import vmicro16_cond_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  push,
    input  logic  pop,
    input  nzcv_t din,
    output nzcv_t dout,
    output logic  full,
    output logic  empty
);

    localparam int unsigned SPW = $clog2(DEPTH + 1);
    localparam int unsigned IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    nzcv_t          mem [DEPTH];
    logic [SPW-1:0] sp;
    logic [SPW-1:0] sp_m1;

    assign sp_m1 = sp - 1'b1;
    assign full  = (sp == SPW'(DEPTH));
    assign empty = (sp == '0);
    assign dout  = empty ? '0 : mem[IW'(sp_m1)];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push && !full) begin
            mem[IW'(sp)] <= din;
            sp           <= sp + 1'b1;
        end else if (pop && !empty) begin
            sp <= sp_m1;
        end
    end

endmodule

// File: rtl/vmicro16_cond_unit.sv
// Per-thread NZCV flag banks with save/restore stacks and a registered BR_* condition evaluator.
module vmicro16_cond_unit
    import vmicro16_cond_unit_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH  = 16,
    parameter  int unsigned NTHREADS    = 4,
    parameter  int unsigned STACK_DEPTH = 4,
    localparam int unsigned TW          = (NTHREADS > 1) ? $clog2(NTHREADS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flags_we,
    input  logic [TW-1:0]         flags_thr,
    input  logic [3:0]            flags_in,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  eval_valid,
    input  logic [TW-1:0]         eval_thr,
    input  logic [7:0]            eval_cond,
    output logic                  res_valid,
    output logic [DATA_WIDTH-1:0] res_out,
    output logic [3:0]            flags_out,
    output logic                  stk_err
);

    function automatic logic cond_eval(input logic n, input logic z, input logic v,
                                       input logic [7:0] code);
        logic lt;
        lt = n ^ v;
        case (code)
            BR_U:    cond_eval = 1'b1;
            BR_E:    cond_eval = z;
            BR_NE:   cond_eval = !z;
            BR_G:    cond_eval = !z && !lt;
            BR_GE:   cond_eval = !lt;
            BR_L:    cond_eval = lt;
            BR_LE:   cond_eval = z || lt;
            default: cond_eval = 1'b0;
        endcase
    endfunction

    nzcv_t               bank     [NTHREADS];
    nzcv_t               bank_nxt [NTHREADS];
    logic [NTHREADS-1:0] err_t;
    nzcv_t               eval_flags;
    logic                eval_hit;
    logic                eval_res;

    // Evaluation reads bank_nxt so a same-cycle write or pop is seen immediately.
    for (genvar t = 0; t < NTHREADS; t++) begin : g_thr
        logic  sel;
        logic  do_push;
        logic  do_pop;
        logic  full;
        logic  empty;
        nzcv_t top;
        nzcv_t bank_q;

        assign sel     = (flags_thr == TW'(t));
        assign do_push = sel & push;
        assign do_pop  = sel & pop;

        vmicro16_flag_stack #(
            .DEPTH (STACK_DEPTH)
        ) u_stack (
            .clk   (clk),
            .reset (reset),
            .push  (do_push & ~do_pop),
            .pop   (do_pop & ~do_push),
            .din   (bank_q),
            .dout  (top),
            .full  (full),
            .empty (empty)
        );

        assign bank_nxt[t] = (do_pop && !do_push && !empty) ? top :
                             (sel && flags_we)               ? flags_in :
                                                               bank_q;
        assign err_t[t] = (do_push & do_pop) |
                          (do_push & ~do_pop & full) |
                          (do_pop & ~do_push & empty);
        assign bank[t] = bank_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) bank_q <= '0;
            else        bank_q <= bank_nxt[t];
        end
    end

    always_comb begin
        eval_flags = '0;
        eval_hit   = 1'b0;
        for (int unsigned i = 0; i < NTHREADS; i++) begin
            if (eval_thr == TW'(i)) begin
                eval_flags = bank_nxt[i];
                eval_hit   = 1'b1;
            end
        end
        eval_res = eval_hit && cond_eval(eval_flags[FLAG_N], eval_flags[FLAG_Z],
                                         eval_flags[FLAG_V], eval_cond);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_valid <= 1'b0;
            res_out   <= '0;
            flags_out <= '0;
            stk_err   <= 1'b0;
        end else begin
            res_valid <= eval_valid;
            res_out   <= (eval_valid && eval_res) ? DATA_WIDTH'(1) : '0;
            flags_out <= eval_flags;
            stk_err   <= |err_t;
        end
    end

endmodule
